// File: rtl/lshift_iter16_if.sv
// Handshake and data bundle for the iterative 16-bit signed left shifter.
interface lshift_iter16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [3:0]  sh;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dataout;
    logic        ovf;

    modport master (
        output in_valid, a, sh, out_ready,
        input  in_ready, out_valid, dataout, ovf
    );

    modport slave (
        input  in_valid, a, sh, out_ready,
        output in_ready, out_valid, dataout, ovf
    );
endinterface

// File: rtl/lshift_iter16.sv
// Iterative signed left shifter: one log stage (8, 4, 2, 1) per clock, fixed 4-cycle latency.
// Optional macro LSHIFT_SAT_EN saturates the result to 0x7FFF/0x8000 on overflow.
module lshift_iter16 (
    input  logic          clk,
    input  logic          reset,
    lshift_iter16_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_work;
    logic [15:0] r_dataout;
    logic [3:0]  r_amt;
    logic [1:0]  r_cnt;
    logic        r_ovf;

    logic [15:0] w_cand;
    logic        w_candOvf;
    logic        w_apply;
    logic [15:0] w_stageOut;
    logic        w_ovfNext;
    logic [15:0] w_result;

    // Candidate shift for the current stage; overflow when the discarded bits plus new sign are not uniform.
    always_comb begin
        w_cand    = r_work;
        w_candOvf = 1'b0;
        w_apply   = 1'b0;
        case (r_cnt)
            2'd0: begin
                w_apply   = r_amt[3];
                w_cand    = {r_work[7:0], 8'h00};
                w_candOvf = !((&r_work[15:7]) || !(|r_work[15:7]));
            end
            2'd1: begin
                w_apply   = r_amt[2];
                w_cand    = {r_work[11:0], 4'h0};
                w_candOvf = !((&r_work[15:11]) || !(|r_work[15:11]));
            end
            2'd2: begin
                w_apply   = r_amt[1];
                w_cand    = {r_work[13:0], 2'b00};
                w_candOvf = !((&r_work[15:13]) || !(|r_work[15:13]));
            end
            default: begin
                w_apply   = r_amt[0];
                w_cand    = {r_work[14:0], 1'b0};
                w_candOvf = r_work[15] ^ r_work[14];
            end
        endcase
    end

    assign w_stageOut = w_apply ? w_cand : r_work;
    assign w_ovfNext  = r_ovf | (w_apply & w_candOvf);

`ifdef LSHIFT_SAT_EN
    logic r_sign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign <= 1'b0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_sign <= bus.a[15];
        end
    end

    assign w_result = w_ovfNext ? (r_sign ? 16'h8000 : 16'h7FFF) : w_stageOut;
`else
    assign w_result = w_stageOut;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = SHIFT;
            SHIFT:   if (r_cnt == 2'd3) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The delivered result lives in its own register so it survives the next operand capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work    <= 16'h0000;
            r_amt     <= 4'h0;
            r_cnt     <= 2'd0;
            r_ovf     <= 1'b0;
            r_dataout <= 16'h0000;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_work <= bus.a;
            r_amt  <= bus.sh;
            r_cnt  <= 2'd0;
            r_ovf  <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_work <= w_stageOut;
            r_ovf  <= w_ovfNext;
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_dataout <= w_result;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.dataout   = r_dataout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_lshift_iter16.sv
// Directed self-checking bench for lshift_iter16 with hand-computed expected results.
module tb_lshift_iter16;
    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;
    int   lat;

    lshift_iter16_if bus ();

    lshift_iter16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LSHIFT_SAT_EN
    localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
    localparam logic [15:0] EXP_4000_1  = 16'h7FFF;
`else
    localparam logic [15:0] EXP_POS_OVF = 16'h8000;
    localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
    localparam logic [15:0] EXP_4000_1  = 16'h8000;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Presents one operand, waits (bounded) for acceptance, then drops in_valid.
    task automatic applyStimulus(input logic [15:0] aVal, input logic [3:0] shVal);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("accept_ready", {15'd0, bus.in_ready}, 16'd1);
        bus.a        = aVal;
        bus.sh       = shVal;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic release_();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 16'h0000;
        bus.sh       = 4'h0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        checkOutput("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        checkOutput("rst_dataout", bus.dataout, 16'h0000);
        checkOutput("rst_ovf", {15'd0, bus.ovf}, 16'd0);
        reset = 1'b0;
        tick();

        applyStimulus(16'hFFF0, 4'd4);
        checkOutput("fff0_busy", {15'd0, bus.in_ready}, 16'd0);
        waitResult(lat);
        checkOutput("fff0_latency", 16'(lat), 16'd4);
        checkOutput("fff0_data", bus.dataout, 16'hFF00);
        checkOutput("fff0_ovf", {15'd0, bus.ovf}, 16'd0);
        release_();
        checkOutput("fff0_drop_valid", {15'd0, bus.out_valid}, 16'd0);
        checkOutput("fff0_idle", {15'd0, bus.in_ready}, 16'd1);
        checkOutput("fff0_data_kept", bus.dataout, 16'hFF00);

        applyStimulus(16'h0001, 4'd15);
        waitResult(lat);
        checkOutput("one_sh15_latency", 16'(lat), 16'd4);
        checkOutput("one_sh15_data", bus.dataout, EXP_POS_OVF);
        checkOutput("one_sh15_ovf", {15'd0, bus.ovf}, 16'd1);
        release_();

        applyStimulus(16'hC000, 4'd2);
        waitResult(lat);
        checkOutput("c000_sh2_data", bus.dataout, EXP_NEG_OVF);
        checkOutput("c000_sh2_ovf", {15'd0, bus.ovf}, 16'd1);
        release_();

        applyStimulus(16'h1234, 4'd0);
        waitResult(lat);
        checkOutput("sh0_latency", 16'(lat), 16'd4);
        checkOutput("sh0_data", bus.dataout, 16'h1234);
        checkOutput("sh0_ovf", {15'd0, bus.ovf}, 16'd0);
        release_();

        // Hold in DONE with out_ready low while inputs wiggle; nothing may change.
        applyStimulus(16'h0003, 4'd2);
        waitResult(lat);
        bus.in_valid = 1'b1;
        bus.a        = 16'hAAAA;
        bus.sh       = 4'd7;
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_valid", {15'd0, bus.out_valid}, 16'd1);
            checkOutput("hold_data", bus.dataout, 16'h000C);
            checkOutput("hold_in_ready", {15'd0, bus.in_ready}, 16'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        checkOutput("hold_valid_end", {15'd0, bus.out_valid}, 16'd1);
        checkOutput("hold_data_end", bus.dataout, 16'h000C);
        release_();
        checkOutput("hold_released", {15'd0, bus.out_valid}, 16'd0);
        checkOutput("hold_idle", {15'd0, bus.in_ready}, 16'd1);

        // Abort during the second SHIFT cycle.
        applyStimulus(16'h0001, 4'd15);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_in_ready", {15'd0, bus.in_ready}, 16'd1);
        checkOutput("abort_out_valid", {15'd0, bus.out_valid}, 16'd0);
        checkOutput("abort_dataout", bus.dataout, 16'h0000);
        checkOutput("abort_ovf", {15'd0, bus.ovf}, 16'd0);
        begin
            logic sawValid;
            sawValid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (bus.out_valid) sawValid = 1'b1;
            end
            checkOutput("abort_no_result", {15'd0, sawValid}, 16'd0);
        end

        // Back-to-back with in_valid and out_ready held high.
        bus.a         = 16'h4000;
        bus.sh        = 4'd1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.a  = 16'h0005;
        bus.sh = 4'd3;
        tick();
        tick();
        tick();
        tick();
        checkOutput("b2b_first_valid", {15'd0, bus.out_valid}, 16'd1);
        checkOutput("b2b_first_data", bus.dataout, EXP_4000_1);
        checkOutput("b2b_first_ovf", {15'd0, bus.ovf}, 16'd1);
        tick();
        checkOutput("b2b_idle_valid", {15'd0, bus.out_valid}, 16'd0);
        checkOutput("b2b_idle_ready", {15'd0, bus.in_ready}, 16'd1);
        tick();
        checkOutput("b2b_second_accepted", {15'd0, bus.in_ready}, 16'd0);
        checkOutput("b2b_ovf_cleared", {15'd0, bus.ovf}, 16'd0);
        bus.in_valid = 1'b0;
        waitResult(lat);
        checkOutput("b2b_second_latency", 16'(lat), 16'd4);
        checkOutput("b2b_second_data", bus.dataout, 16'h0028);
        checkOutput("b2b_second_ovf", {15'd0, bus.ovf}, 16'd0);
        bus.out_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/lshift_iter16.md
LSHIFT_ITER16 -- requirements
Module: lshift_iter16

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand and shift amount are present.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a new operand.
REQ-005 SHALL have port a, input, 16 bits: signed two's-complement operand.
REQ-006 SHALL have port sh, input, 4 bits: left-shift amount, 0..15.
REQ-007 SHALL have port out_valid, output, 1 bit: result is available.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port dataout, output, 16 bits: shifted result.
REQ-010 SHALL have port ovf, output, 1 bit: signed overflow occurred; valid while out_valid is high.

Function
REQ-011 SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE; it SHALL NOT bypass DONE to IDLE in the same cycle.
REQ-013 SHALL, on an edge with in_valid&&in_ready, capture a into the working register and sh into the amount register, clear ovf, zero the 2-bit stage counter, and enter SHIFT.
REQ-014 SHALL, in SHIFT, apply one log stage per cycle in the fixed order 8, 4, 2, 1, with stage k applied only when its bit of sh is set; zeros SHALL fill the vacated LSBs.
REQ-015 SHALL spend every cycle of all four stages even when a stage's bit is clear; latency is exactly 4 clocks from the acceptance edge to out_valid=1.
REQ-016 SHALL set ovf (sticky within the operation) when an applied stage of k discards bits that are not all equal to the resulting bit 15, i.e. when current bits [15:15-k] are not uniform.
REQ-017 SHALL enter DONE after the fourth stage edge and hold out_valid=1 with dataout and ovf stable until out_ready=1.
REQ-018 SHALL, on an edge with out_valid&&out_ready, return to IDLE and drop out_valid; dataout SHALL keep its last value.
REQ-019 SHALL ignore in_valid and input changes outside IDLE.
REQ-020 SHALL ignore out_ready outside DONE.

Reset
REQ-021 SHALL, when reset=1 on an edge, enter IDLE and set dataout=0x0000, ovf=0, out_valid=0, in_ready=1 and stage counter=0.
REQ-022 SHALL let reset take priority over every handshake; reset during SHIFT or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-023 SHALL, with macro LSHIFT_SAT_EN defined and ovf=1 at completion, replace dataout with 0x7FFF when the captured a[15]=0 and with 0x8000 when a[15]=1.
REQ-024 SHALL, without LSHIFT_SAT_EN, deliver the wrapped zero-fill result; ovf SHALL still be reported identically.

Verification
REQ-025 SHALL cover: a=0xFFF0, sh=4 -> out_valid exactly 4 clocks after acceptance, dataout=0xFF00, ovf=0.
REQ-026 SHALL cover: a=0x0001, sh=15 -> ovf=1; dataout=0x8000 without the macro, 0x7FFF with LSHIFT_SAT_EN.
REQ-027 SHALL cover: a=0x1234, sh=0 -> dataout=0x1234, ovf=0, latency still 4 clocks.
REQ-028 SHALL cover: out_ready held low 3 cycles in DONE -> out_valid=1 and dataout stable throughout, in_ready=0 throughout, then IDLE one edge after out_ready=1.
REQ-029 SHALL cover: reset asserted on the 2nd SHIFT cycle -> next cycle in_ready=1, out_valid=0, dataout=0x0000, and no result is delivered.
REQ-030 SHALL cover: back-to-back operations with in_valid held high -> second operand accepted on the first IDLE cycle after the result handshake, with ovf from the first operation not carried over.
